// File: rtl/buble_rr_arb_if.sv
// buble_rr_arb_if: requester-side and output-side valid/ready bundle for buble_rr_arb
interface buble_rr_arb_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ*WIDTH-1:0] data_a;
  logic [NUM_REQ-1:0]       vld_a;
  logic [NUM_REQ-1:0]       last_a;
  logic [NUM_REQ-1:0]       rdy_a;
  logic [WIDTH-1:0]         data_b;
  logic [IDW-1:0]           id_b;
  logic                     last_b;
  logic                     vld_b;
  logic                     rdy_b;
  logic                     busy;
  modport master (
    output data_a, vld_a, last_a, rdy_b,
    input  rdy_a, data_b, id_b, last_b, vld_b, busy
  );
  modport slave (
    input  data_a, vld_a, last_a, rdy_b,
    output rdy_a, data_b, id_b, last_b, vld_b, busy
  );
endinterface

// File: rtl/buble_rr_arb.sv
// buble_rr_arb: burst-aware round-robin arbiter feeding one registered valid/ready output stage
module buble_rr_arb #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input logic           clk,
  input logic           rst,
  buble_rr_arb_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           state, state_n;
  logic [IDW-1:0]   ptr, ptr_n, owner, owner_n, rr_gnt, gnt;
  logic [CW-1:0]    cnt, cnt_n;
  logic             any, gnt_vld, can_load, xfer, last_in, force_rel;
  logic [WIDTH-1:0] lane [NUM_REQ];
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    return IDW'(s >= NUM_REQ ? s - NUM_REQ : s);
  endfunction
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = bus.data_a[i*WIDTH +: WIDTH];
  end
  always_comb begin
    rr_gnt = ptr;
    any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.vld_a[wrap_add(ptr, k)]) begin
        rr_gnt = wrap_add(ptr, k);
        any    = 1'b1;
      end
    end
  end
  assign can_load  = !bus.vld_b || bus.rdy_b;
  assign gnt       = state == LOCK ? owner : rr_gnt;
  assign gnt_vld   = state == LOCK ? bus.vld_a[owner] : any;
  assign xfer      = gnt_vld && can_load && !rst;
  assign bus.rdy_a = xfer ? NUM_REQ'(1) << gnt : '0;
  assign last_in   = bus.last_a[gnt];
  assign force_rel = MAX_BURST == 1 || (state == LOCK && cnt == CW'(MAX_BURST - 1));
  assign bus.busy  = state == LOCK;
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    if (xfer) begin
      state_n = (last_in || force_rel) ? IDLE : LOCK;
      ptr_n   = (last_in || force_rel) ? wrap_add(gnt, 1) : ptr;
      owner_n = gnt;
      cnt_n   = (last_in || force_rel) ? '0 : (state == IDLE ? CW'(1) : cnt + CW'(1));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vld_b  <= 1'b0;
      bus.last_b <= 1'b0;
      bus.data_b <= '0;
      bus.id_b   <= '0;
    end else if (xfer) begin
      bus.vld_b  <= 1'b1;
      bus.last_b <= last_in || force_rel;
      bus.data_b <= lane[gnt];
      bus.id_b   <= gnt;
    end else if (bus.rdy_b) begin
      bus.vld_b  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_buble_rr_arb.sv
// tb_buble_rr_arb: directed checks of arbitration order, burst lock, forced release and backpressure
module tb_buble_rr_arb;
  localparam int W = 32;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  buble_rr_arb_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
  buble_rr_arb #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  int bcnt [N];
  int blen [N];
  int bp [15] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int exp_id [6] = '{2, 2, 2, 2, 3, 2};
  int exp_last [6] = '{0, 0, 0, 1, 1, 0};
  logic [N-1:0] ven, ra;
  logic rb, bz, hv;
  logic [W-1:0] hd;
  logic [1:0] hi;
  logic [39:0] q [$];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.data_a[i*W +: W] = {8'(i), 24'(bcnt[i])};
      bus.last_a[i] = blen[i] != 0 && bcnt[i] % blen[i] == blen[i] - 1;
    end
    bus.vld_a = ven;
    bus.rdy_b = rb;
  endtask
  task automatic step();
    logic [N-1:0] xf;
    logic [39:0] f;
    drive();
    #1;
    ra = bus.rdy_a;
    bz = bus.busy;
    xf = bus.vld_a & bus.rdy_a;
    if (bus.vld_b && bus.rdy_b) begin
      check("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        f = q.pop_front();
        check("sb_beat", {bus.id_b, 6'd0, bus.data_b}, {f[33:32], 6'd0, f[31:0]});
      end
    end
    for (int i = 0; i < N; i++)
      if (xf[i]) q.push_back({8'(i), bus.data_a[i*W +: W]});
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (xf[i]) bcnt[i]++;
    if (rst) q.delete();
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    ven = '1;
    rb = 1'b1;
    for (int i = 0; i < N; i++) blen[i] = 1;
    repeat (3) begin
      step();
      check("rst_rdy", ra, 0);
      check("rst_vld", bus.vld_b, 0);
      check("rst_data", bus.data_b, 0);
      check("rst_busy", bus.busy, 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) check("first_grant", ra, 4'b0001);
      if (k == 1) check("rr_data", bus.data_b, 32'h0100_0000);
      check("rr_id", bus.id_b, 64'(k % 4));
      check("rr_vld", bus.vld_b, 1);
      check("rr_last", bus.last_b, 1);
    end
    ven = '0;
    step();
    check("drain_vld", bus.vld_b, 0);
    bcnt[1] = 0;
    blen[1] = 3;
    ven = 4'b0010;
    step();
    check("lock_id_b1", bus.id_b, 1);
    check("lock_busy_b1", bus.busy, 1);
    ven = 4'b0111;
    step();
    check("lock_rdy", ra, 4'b0010);
    check("lock_id_b2", bus.id_b, 1);
    check("lock_busy_b2", bz, 1);
    step();
    check("lock_id_b3", bus.id_b, 1);
    check("lock_busy_b3", bz, 1);
    check("lock_last_b3", bus.last_b, 1);
    check("lock_release", bus.busy, 0);
    ven = 4'b0101;
    step();
    check("post_lock_id2", bus.id_b, 2);
    step();
    check("post_lock_id0", bus.id_b, 0);
    ven = '0;
    step();
    bcnt[2] = 0;
    blen[2] = 0;
    blen[3] = 1;
    ven = 4'b1100;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) ven = 4'b0100;
      step();
      check("force_id", bus.id_b, 64'(exp_id[k]));
      check("force_last", bus.last_b, 64'(exp_last[k]));
      if (k == 3) check("force_data", bus.data_b, 32'h0200_0003);
    end
    bcnt[0] = 0;
    blen[0] = 2;
    ven = 4'b0101;
    for (int k = 0; k < 15; k++) begin
      rb = bp[k][0];
      hd = bus.data_b;
      hi = bus.id_b;
      hv = bus.vld_b;
      step();
      if (!rb && hv) begin
        check("bp_rdy", ra, 0);
        check("bp_data", bus.data_b, hd);
        check("bp_id", bus.id_b, hi);
        check("bp_vld", bus.vld_b, 1);
      end
    end
    rb = 1'b1;
    ven = '0;
    step();
    step();
    check("bp_sb_empty", q.size(), 0);
    check("bp_drain_vld", bus.vld_b, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) bcnt[i] = 0;
    blen[0] = 3;
    blen[1] = 1;
    ven = 4'b0001;
    step();
    check("stall_id_b1", bus.id_b, 0);
    check("stall_busy", bus.busy, 1);
    ven = 4'b0010;
    repeat (4) begin
      step();
      check("stall_rdy", ra, 0);
      check("stall_vld", bus.vld_b, 0);
    end
    ven = 4'b0011;
    step();
    check("stall_id_b2", bus.id_b, 0);
    check("stall_data_b2", bus.data_b, 32'h0000_0001);
    step();
    check("stall_id_b3", bus.id_b, 0);
    check("stall_last_b3", bus.last_b, 1);
    step();
    check("stall_next_id", bus.id_b, 1);
    bcnt[0] = 0;
    ven = 4'b0001;
    step();
    check("rstmid_id_b1", bus.id_b, 0);
    check("rstmid_busy", bus.busy, 1);
    step();
    check("rstmid_id_b2", bus.id_b, 0);
    rst = 1'b1;
    ven = 4'b0010;
    step();
    check("rstmid_vld", bus.vld_b, 0);
    check("rstmid_busy_clr", bus.busy, 0);
    rst = 1'b0;
    step();
    check("rstmid_rdy", ra, 4'b0010);
    check("rstmid_id", bus.id_b, 1);
    check("rstmid_vld_new", bus.vld_b, 1);
    ven = '0;
    step();
    step();
    check("final_sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
